// File: rtl/ula_op_sequencer_if.sv
// Request/response handshake bundle between a client and the ULA operation sequencer.
// Master issues operand requests and consumes results; slave is the sequencer.
interface ula_op_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] req_cond;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_out;
    logic       rsp_carry;
    logic [1:0] rsp_cond;

    modport master (
        output req_valid, req_a, req_b, req_cond, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_carry, rsp_cond
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cond, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_carry, rsp_cond
    );
endinterface

// File: rtl/ula_op_sequencer.sv
// Queues ULA requests, holds each on the ULA for SETTLE_CYC cycles, captures OUT/CARRY; rsp_valid at push+2+SETTLE_CYC.
// Backpressure: req_ready drops when the FIFO is full; a stalled response holds all rsp_* and stops issue.
module ula_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ula_op_sequencer_if.slave    bus,
    output logic [7:0]           ula_a,
    output logic [7:0]           ula_b,
    output logic [1:0]           ula_cond,
    input  logic [7:0]           ula_out,
    input  logic                 ula_carry,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count,
    output logic [CNT_W-1:0]     carry_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [PW:0]   PTR_ONE   = (PW + 1)'(1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] cond;
    } req_t;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

    req_t        mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty, push, pop;
    req_t        head;

    state_t      state;
    logic [SW-1:0] settle_cnt;
    logic        rsp_valid_q, rsp_carry_q;
    logic [7:0]  rsp_out_q;
    logic [1:0]  rsp_cond_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push       = bus.req_valid && !fifo_full;
    assign pop        = !fifo_empty && ((state == IDLE) || (state == RESP && bus.rsp_ready));
    assign head       = mem[rd_ptr[PW-1:0]];

    assign bus.req_ready = !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_cond  = rsp_cond_q;
    assign busy          = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= '{a: bus.req_a, b: bus.req_b, cond: bus.req_cond};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            ula_a       <= '0;
            ula_b       <= '0;
            ula_cond    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_cond_q  <= '0;
            op_count    <= '0;
            carry_count <= '0;
        end else begin
            // A response handshake with work queued issues straight into SETTLE.
            if (pop) begin
                ula_a      <= head.a;
                ula_b      <= head.b;
                ula_cond   <= head.cond;
                settle_cnt <= SETTLE_LD;
            end
            case (state)
                IDLE: begin
                    if (pop) state <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - SW'(1);
                    if (settle_cnt == SW'(1)) state <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_out_q   <= ula_out;
                    rsp_carry_q <= ula_carry;
                    rsp_cond_q  <= ula_cond;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count    <= op_count + CNT_W'(1);
                        carry_count <= carry_count + CNT_W'(rsp_carry_q);
                        state       <= pop ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_op_sequencer.sv
module tb_ula_op_sequencer;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       ula_a, ula_b, ula_out;
    logic [1:0]       ula_cond;
    logic             ula_carry;
    logic             busy;
    logic [CNT_W-1:0] op_count, carry_count;

    int n_checks = 0;
    int n_fail   = 0;
    int k, last, cyc, n;

    logic [7:0] fa [5] = '{8'h10, 8'h05, 8'h33, 8'h00, 8'h80};
    logic [7:0] fb [5] = '{8'h20, 8'h07, 8'h33, 8'h00, 8'h80};
    logic [1:0] fc [5] = '{2'd0,  2'd1,  2'd2,  2'd3,  2'd0};
    logic [7:0] fo [5] = '{8'h30, 8'hFE, 8'h01, 8'h00, 8'h00};
    logic       fk [5] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1};

    ula_op_sequencer_if bus ();

    ula_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYC(1), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_cond   (ula_cond),
        .ula_out    (ula_out),
        .ula_carry  (ula_carry),
        .busy       (busy),
        .op_count   (op_count),
        .carry_count(carry_count)
    );

    always #5 clk = ~clk;

    // Combinational ULA: add, sub (carry = borrow), equal, any-is-one.
    always_comb begin
        {ula_carry, ula_out} = 9'h000;
        case (ula_cond)
            2'd0: {ula_carry, ula_out} = {1'b0, ula_a} + {1'b0, ula_b};
            2'd1: {ula_carry, ula_out} = {1'b0, ula_a} - {1'b0, ula_b};
            2'd2: {ula_carry, ula_out} = {8'h00, (ula_a == ula_b)};
            default: {ula_carry, ula_out} = {8'h00, |(ula_a | ula_b)};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
        int w;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_cond = c;
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 50) begin
            tick();
            w++;
        end
        if (!bus.req_ready) check("push_timeout", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cnt);
        cnt = 0;
        while (!bus.rsp_valid && cnt < 50) begin
            tick();
            cnt++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 1);
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] c, input logic [7:0] eo, input logic ec);
        int w;
        push(a, b, c);
        wait_rsp(w);
        check({tag, "_out"}, 32'(bus.rsp_out), 32'(eo));
        check({tag, "_carry"}, 32'(bus.rsp_carry), 32'(ec));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_cond = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_ula", 32'({ula_a, ula_b, ula_cond}), 0);
        check("rst_rsp", 32'({bus.rsp_out, bus.rsp_carry, bus.rsp_cond}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_counts", 32'({op_count, carry_count}), 0);
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 1);

        // First op: latency 3 from the push edge
        push(8'h06, 8'h60, 2'd0);
        tick(); tick();
        check("lat_early", 32'(bus.rsp_valid), 0);
        tick();
        check("lat3_valid", 32'(bus.rsp_valid), 1);
        check("op1_out", 32'(bus.rsp_out), 32'h66);
        check("op1_carry", 32'(bus.rsp_carry), 0);
        check("op1_cond", 32'(bus.rsp_cond), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("op1_valid_clr", 32'(bus.rsp_valid), 0);
        check("op1_opcnt", 32'(op_count), 1);
        check("op1_carrycnt", 32'(carry_count), 0);

        // Carry-out
        do_op("op2", 8'hFF, 8'h01, 2'd0, 8'h00, 1'b1);
        check("op2_opcnt", 32'(op_count), 2);
        check("op2_carrycnt", 32'(carry_count), 1);

        // Fill FIFO behind a stalled response
        for (int i = 0; i < 5; i++) begin
            bus.req_a = fa[i];
            bus.req_b = fb[i];
            bus.req_cond = fc[i];
            bus.req_valid = 1'b1;
            check("fifo_accept", 32'(bus.req_ready), 1);
            tick();
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fifo_full_rdy", 32'(bus.req_ready), 0);
            tick();
        end
        check("fifo_hold_valid", 32'(bus.rsp_valid), 1);

        bus.rsp_ready = 1'b1;
        k = 0; last = 0; cyc = 0;
        while (k < 5 && cyc < 60) begin
            if (bus.rsp_valid) begin
                check("fifo_out", 32'(bus.rsp_out), 32'(fo[k]));
                check("fifo_carry", 32'(bus.rsp_carry), 32'(fk[k]));
                check("fifo_cond", 32'(bus.rsp_cond), 32'(fc[k]));
                if (k > 0) check("fifo_gap", 32'(cyc - last), 3);
                last = cyc;
                k++;
            end
            tick();
            cyc++;
            if (k == 1 && cyc == last + 1) check("fifo_rdy_free", 32'(bus.req_ready), 1);
        end
        bus.rsp_ready = 1'b0;
        if (k < 5) check("fifo_timeout", 32'(k), 5);
        check("fifo_opcnt", 32'(op_count), 7);
        check("fifo_carrycnt", 32'(carry_count), 3);

        // Long stall: response and counters stay put
        push(8'h00, 8'h04, 2'd3);
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(bus.rsp_valid), 1);
            check("stall_rsp", 32'({bus.rsp_out, bus.rsp_carry, bus.rsp_cond}), 32'({8'h01, 1'b0, 2'd3}));
            check("stall_opcnt", 32'(op_count), 7);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("stall_opcnt_after", 32'(op_count), 8);

        // Reset during SETTLE with two entries queued
        push(8'h01, 8'h02, 2'd0);
        wait_rsp(n);
        push(8'h11, 8'h22, 2'd0);
        push(8'h21, 8'h22, 2'd1);
        push(8'h31, 8'h22, 2'd2);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("mid_busy", 32'(busy), 1);
        check("mid_ula_a", 32'(ula_a), 32'h11);
        rst_n = 1'b0;
        #1;
        check("arst_ula", 32'({ula_a, ula_b, ula_cond}), 0);
        check("arst_rsp", 32'({bus.rsp_valid, bus.rsp_out, bus.rsp_carry, bus.rsp_cond}), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_counts", 32'({op_count, carry_count}), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("arst_req_ready", 32'(bus.req_ready), 1);
        for (int i = 0; i < 10; i++) begin
            check("arst_no_rsp", 32'({bus.rsp_valid, busy}), 0);
            tick();
        end

        // Counter wrap at CNT_W=4
        for (int i = 1; i <= 17; i++) begin
            do_op("wrap", 8'(i), 8'(i), 2'd0, 8'(2 * i), 1'b0);
            if (i == 16) check("wrap_opcnt16", 32'(op_count), 0);
        end
        check("wrap_opcnt17", 32'(op_count), 1);
        check("wrap_carrycnt", 32'(carry_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
